// File: rtl/mips_mem_responder.sv
// Memory-side responder for the multicycle MIPS core: text/data RAM plus MMIO.
// Console FIFO (TXDATA/STATUS) is built only when MIPS_MEM_CONSOLE_EN is defined.
module mips_mem_responder #(
  parameter int TEXT_WORDS = 1024,
  parameter int DATA_WORDS = 1024,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wr_data,
  input  logic        mem_wr_ena,
  output logic [31:0] mem_rd_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        bus_error
);

  localparam int TA = $clog2(TEXT_WORDS);
  localparam int DA = $clog2(DATA_WORDS);
  localparam logic [29:0] TextBase = 30'h0010_0000;
  localparam logic [29:0] DataBase = 30'h0400_4000;

  logic [29:0] wordIdx;
  logic [29:0] textOff;
  logic [29:0] dataOff;
  logic        textHit;
  logic        dataHit;
  logic        mmioHit;
  logic        unmapped;
  logic        wrEna;
  logic        wrCycle;
  logic        wrScratch;
  logic [31:0] cycleCnt;
  logic [31:0] scratch;
  logic [31:0] status;
  logic [31:0] rdData;
  logic        busErr;
  logic        unusedAddrBits;

  logic [31:0] textRam [TEXT_WORDS];
  logic [31:0] dataRam [DATA_WORDS];

  assign wordIdx  = mem_addr[31:2];
  assign textOff  = wordIdx - TextBase;
  assign dataOff  = wordIdx - DataBase;
  assign textHit  = textOff < 30'(TEXT_WORDS);
  assign dataHit  = !textHit && (dataOff < 30'(DATA_WORDS));
  assign mmioHit  = mem_addr[31:4] == 28'hFFFF000;
  assign unmapped = !(textHit || dataHit || mmioHit);
  assign unusedAddrBits = ^mem_addr[1:0];

  assign wrEna     = mem_wr_ena && !rst;
  assign wrCycle   = wrEna && mmioHit && (wordIdx[1:0] == 2'd2);
  assign wrScratch = wrEna && mmioHit && (wordIdx[1:0] == 2'd3);

  always_ff @(posedge clk) begin
    if (wrEna && textHit) textRam[textOff[TA-1:0]] <= mem_wr_data;
    if (wrEna && dataHit) dataRam[dataOff[DA-1:0]] <= mem_wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busErr   <= 1'b0;
      cycleCnt <= 32'd0;
      scratch  <= 32'd0;
    end else begin
      busErr   <= busErr || (mem_wr_ena && unmapped);
      cycleCnt <= wrCycle ? mem_wr_data : cycleCnt + 32'd1;
      if (wrScratch) scratch <= mem_wr_data;
    end
  end

  assign bus_error = busErr;

`ifdef MIPS_MEM_CONSOLE_EN
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [7:0]    fifoMem [FIFO_DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic          overflow;
  logic          full;
  logic          empty;
  logic          pushReq;
  logic          push;
  logic          pop;
  logic          wrStatus;

  assign full     = count == CW'(FIFO_DEPTH);
  assign empty    = count == '0;
  assign pushReq  = wrEna && mmioHit && (wordIdx[1:0] == 2'd0);
  assign wrStatus = wrEna && mmioHit && (wordIdx[1:0] == 2'd1);
  assign pop      = !empty && tx_ready;
  // A pop on a full FIFO frees the slot the simultaneous push needs.
  assign push     = pushReq && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) fifoMem[tail] <= mem_wr_data[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (wrStatus && mem_wr_data[2]) overflow <= 1'b0;
      else if (pushReq && !push) overflow <= 1'b1;
    end
  end

  assign tx_valid = !empty;
  assign tx_data  = empty ? 8'd0 : fifoMem[head];
  assign status   = {20'd0, 4'(count), 5'd0, overflow, full, empty};
`else
  logic unusedTxReady;

  assign unusedTxReady = tx_ready;
  assign tx_valid      = 1'b0;
  assign tx_data       = 8'd0;
  assign status        = 32'd0;
`endif

  always_comb begin
    rdData = 32'hDEADBEEF;
    unique case (1'b1)
      textHit:  rdData = textRam[textOff[TA-1:0]];
      dataHit:  rdData = dataRam[dataOff[DA-1:0]];
      mmioHit: begin
        case (wordIdx[1:0])
          2'd0:    rdData = 32'd0;
          2'd1:    rdData = status;
          2'd2:    rdData = cycleCnt;
          default: rdData = scratch;
        endcase
      end
      unmapped: rdData = 32'hDEADBEEF;
      default:  rdData = 32'hDEADBEEF;
    endcase
  end

  assign mem_rd_data = rst ? 32'd0 : (unusedAddrBits ? rdData : rdData);

endmodule

// File: tb/tb_mips_mem_responder.sv
// Directed bench for mips_mem_responder: RAM, decode, CYCLE, SCRATCH, console.
// Console checks follow MIPS_MEM_CONSOLE_EN the same way the design does.
module tb_mips_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic        mem_wr_ena;
  logic [31:0] mem_rd_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        bus_error;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] TxAddr  = 32'hFFFF_0000;
  localparam logic [31:0] StAddr  = 32'hFFFF_0004;
  localparam logic [31:0] CycAddr = 32'hFFFF_0008;
  localparam logic [31:0] ScrAddr = 32'hFFFF_000C;

  mips_mem_responder dut (
    .clk         (clk),
    .rst         (rst),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_wr_ena  (mem_wr_ena),
    .mem_rd_data (mem_rd_data),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .bus_error   (bus_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    mem_addr    = a;
    mem_wr_data = d;
    mem_wr_ena  = 1'b1;
    @(negedge clk);
    mem_wr_ena  = 1'b0;
    #1;
  endtask

  task automatic rd(input string tag,
                    input logic [31:0] a,
                    input logic [31:0] exp);
    mem_addr = a;
    #1;
    check(tag, mem_rd_data, exp);
  endtask

  task automatic pulseReset;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_forces_rd0", mem_rd_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst         = 1'b1;
    mem_addr    = 32'd0;
    mem_wr_data = 32'd0;
    mem_wr_ena  = 1'b0;
    tx_ready    = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_rd", mem_rd_data, 32'd0);
    check("reset_txv", tx_valid, 1'b0);
    check("reset_txd", tx_data, 8'd0);
    check("reset_berr", bus_error, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    rd("reset_cycle", CycAddr, 32'd0);
    rd("reset_scratch", ScrAddr, 32'd0);

    wr(32'h1001_0004, 32'h1234_5678);
    rd("data_rd", 32'h1001_0004, 32'h1234_5678);
    rd("data_lowbits", 32'h1001_0006, 32'h1234_5678);
    wr(32'h0040_0000, 32'hCAFE_F00D);
    rd("text_rd", 32'h0040_0000, 32'hCAFE_F00D);
    wr(32'h1001_0FFC, 32'hA5A5_5A5A);
    rd("data_last", 32'h1001_0FFC, 32'hA5A5_5A5A);
    wr(32'h0040_0FFC, 32'h0BAD_F00D);
    rd("text_last", 32'h0040_0FFC, 32'h0BAD_F00D);
    rd("data_first_kept", 32'h1001_0004, 32'h1234_5678);
    rd("data_past_end", 32'h1001_1000, 32'hDEAD_BEEF);
    rd("text_past_end", 32'h0040_1000, 32'hDEAD_BEEF);
    rd("mmio_past_end", 32'hFFFF_0010, 32'hDEAD_BEEF);
    rd("unmapped_rd", 32'h2000_0000, 32'hDEAD_BEEF);
    check("unmapped_rd_berr", bus_error, 1'b0);

    wr(ScrAddr, 32'h1357_9BDF);
    rd("scratch_rd", ScrAddr, 32'h1357_9BDF);

    wr(CycAddr, 32'hFFFF_FFFE);
    rd("cycle_0", CycAddr, 32'hFFFF_FFFE);
    @(negedge clk);
    rd("cycle_1", CycAddr, 32'hFFFF_FFFF);
    @(negedge clk);
    rd("cycle_wrap", CycAddr, 32'h0000_0000);

`ifdef MIPS_MEM_CONSOLE_EN
    rd("st_idle", StAddr, 32'h0000_0001);
    for (int i = 0; i < 8; i++) wr(TxAddr, 32'h41 + i);
    rd("st_full", StAddr, 32'h0000_0802);
    check("head_41", tx_data, 8'h41);
    wr(TxAddr, 32'h49);
    rd("st_ovf", StAddr, 32'h0000_0806);
    rd("txdata_rd0", TxAddr, 32'd0);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain_valid", tx_valid, 1'b1);
      check("drain_byte", tx_data, 8'h41 + 8'(i));
      @(negedge clk);
      #1;
    end
    check("drain_done", tx_valid, 1'b0);
    tx_ready = 1'b0;
    rd("st_empty_ovf", StAddr, 32'h0000_0005);
    wr(StAddr, 32'h4);
    rd("st_ovf_clr", StAddr, 32'h0000_0001);

    for (int i = 0; i < 8; i++) wr(TxAddr, 32'h50 + i);
    @(negedge clk);
    mem_addr    = TxAddr;
    mem_wr_data = 32'h58;
    mem_wr_ena  = 1'b1;
    tx_ready    = 1'b1;
    @(negedge clk);
    mem_wr_ena  = 1'b0;
    tx_ready    = 1'b0;
    rd("st_pushpop_full", StAddr, 32'h0000_0802);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("pp_byte", tx_data, 8'h51 + 8'(i));
      @(negedge clk);
      #1;
    end
    tx_ready = 1'b0;
    rd("st_pp_done", StAddr, 32'h0000_0001);

    for (int i = 0; i < 3; i++) wr(TxAddr, 32'h60 + i);
    check("q3_valid", tx_valid, 1'b1);
    pulseReset();
    check("rst_flush_valid", tx_valid, 1'b0);
    check("rst_flush_data", tx_data, 8'd0);
    rd("rst_flush_st", StAddr, 32'h0000_0001);
    rd("rst_cycle", CycAddr, 32'd0);
`else
    wr(TxAddr, 32'h41);
    check("nocon_txv", tx_valid, 1'b0);
    check("nocon_berr", bus_error, 1'b0);
    rd("nocon_st", StAddr, 32'd0);
    rd("nocon_tx", TxAddr, 32'd0);
    wr(StAddr, 32'h4);
    check("nocon_st_berr", bus_error, 1'b0);
    pulseReset();
    rd("rst_cycle", CycAddr, 32'd0);
    rd("rst_scratch", ScrAddr, 32'd0);
`endif

    wr(32'h2000_0000, 32'h1);
    check("berr_set", bus_error, 1'b1);
    rd("berr_no_store", 32'h2000_0000, 32'hDEAD_BEEF);
    @(negedge clk);
    #1;
    check("berr_sticky", bus_error, 1'b1);
    pulseReset();
    check("berr_rst", bus_error, 1'b0);
    rd("ram_kept_rst", 32'h1001_0004, 32'h1234_5678);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
